// File: rtl/softmax_pkg.sv
// Shared types, widths and helpers for the softmax approximation pipeline.
// Used by max-forwarding and max-subtract stages alike.
package softmax_pkg;

  localparam int LANES = 64;
  localparam int W     = 16;

  localparam logic [W-1:0] MAX_NEG = 16'h8000;

  // Modes 3..13 encode groups of (mode-1) beats; anything else is a single beat.
  function automatic logic [3:0] mode_to_len(input logic [3:0] mode);
    if (mode >= 4'd3 && mode <= 4'd13) begin
      return mode - 4'd1;
    end
    return 4'd1;
  endfunction

  function automatic logic [W-1:0] lane_slice(input logic [LANES*W-1:0] flat,
                                              input int unsigned k);
    return flat[k*W +: W];
  endfunction

endpackage

// File: rtl/sat_sub_lane.sv
// One lane of x - max at W+1 bits, clamped to [MAX_NEG, 0].
// Purely combinational; the parent owns all pipeline registers.
module sat_sub_lane
  import softmax_pkg::*;
(
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] max_i,
  output logic [W-1:0] diff_o
);

  logic [W:0] d;

  assign d = {x_i[W-1], x_i} - {max_i[W-1], max_i};

  always_comb begin
    diff_o = d[W-1:0];
    if (!d[W] && (d[W-1:0] != '0)) begin
      // Positive difference only happens if the max lags a lane; pin to zero.
      diff_o = '0;
    end else if (d[W] && !d[W-1]) begin
      diff_o = MAX_NEG;
    end
  end

endmodule

// File: rtl/max_sub_norm.sv
// Subtracts the group-aligned global max from every lane with saturation,
// tags group first/last beats and flags a max that changes inside a group.
module max_sub_norm
  import softmax_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic               i_valid,
  input  logic [W-1:0]       i_global_max,
  input  logic [3:0]         i_length_mode,
  input  logic [LANES*W-1:0] i_in_flat,
  output logic               o_valid,
  output logic [LANES*W-1:0] o_diff_flat,
  output logic               o_first,
  output logic               o_last,
  output logic [3:0]         o_length_mode,
  output logic               o_err_max
);

  // Handshake: a beat is accepted on any clock edge with i_en && i_valid;
  // there is no ready, i_en is the only stall and it freezes everything.

  logic [3:0]   cnt_q, cnt_d;
  logic [3:0]   mode_q, mode_d;
  logic [W-1:0] max_q, max_d;

  logic         first_c, last_c, mism_c;
  logic [3:0]   len_c, eff_mode_c;

  logic               s1_valid_q, s1_first_q, s1_last_q, s1_err_q;
  logic [3:0]         s1_mode_q;
  logic [W-1:0]       s1_max_q;
  logic [LANES*W-1:0] s1_x_q;

  logic [LANES*W-1:0] diff_c;

  logic               valid_q, first_q, last_q, err_q;
  logic [3:0]         mode_out_q;
  logic [LANES*W-1:0] diff_q;

  always_comb begin
    first_c    = (cnt_q == 4'd0);
    eff_mode_c = first_c ? i_length_mode : mode_q;
    len_c      = mode_to_len(eff_mode_c);
    last_c     = (cnt_q == len_c - 4'd1);
    mism_c     = i_valid && !first_c && (i_global_max != max_q);
  end

  always_comb begin
    cnt_d  = cnt_q;
    mode_d = mode_q;
    max_d  = max_q;
    if (i_valid) begin
      if (first_c) begin
        mode_d = i_length_mode;
        max_d  = i_global_max;
      end
      cnt_d = last_c ? 4'd0 : cnt_q + 4'd1;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    sat_sub_lane u_lane (
      .x_i   (lane_slice(s1_x_q, k)),
      .max_i (s1_max_q),
      .diff_o(diff_c[k*W +: W])
    );
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q      <= 4'd0;
      mode_q     <= 4'd0;
      max_q      <= MAX_NEG;
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_err_q   <= 1'b0;
      s1_mode_q  <= 4'd0;
      s1_max_q   <= '0;
      s1_x_q     <= '0;
      valid_q    <= 1'b0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
      mode_out_q <= 4'd0;
      diff_q     <= '0;
    end else if (i_en) begin
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      max_q      <= max_d;
      s1_valid_q <= i_valid;
      s1_first_q <= i_valid && first_c;
      s1_last_q  <= i_valid && last_c;
      s1_err_q   <= mism_c;
      s1_mode_q  <= eff_mode_c;
      s1_max_q   <= i_global_max;
      s1_x_q     <= i_in_flat;
      valid_q    <= s1_valid_q;
      first_q    <= s1_first_q;
      last_q     <= s1_last_q;
      mode_out_q <= s1_mode_q;
      diff_q     <= diff_c;
      // Error is carried one stage so it surfaces alongside the offending beat.
      err_q      <= err_q | s1_err_q;
    end
  end

  assign o_valid       = valid_q;
  assign o_diff_flat   = diff_q;
  assign o_first       = first_q;
  assign o_last        = last_q;
  assign o_length_mode = mode_out_q;
  assign o_err_max     = err_q;

endmodule

// File: tb/tb_max_sub_norm.sv
// Scoreboard bench for max_sub_norm: a behavioural group/lane model queues
// expected beats at drive time; a negedge monitor pops and compares them.
module tb_max_sub_norm;
  import softmax_pkg::*;

  logic               i_clk, i_rst, i_en, i_valid;
  logic [W-1:0]       i_global_max;
  logic [3:0]         i_length_mode;
  logic [LANES*W-1:0] i_in_flat;
  logic               o_valid, o_first, o_last, o_err_max;
  logic [LANES*W-1:0] o_diff_flat;
  logic [3:0]         o_length_mode;

  max_sub_norm dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_valid(i_valid),
    .i_global_max(i_global_max), .i_length_mode(i_length_mode),
    .i_in_flat(i_in_flat), .o_valid(o_valid), .o_diff_flat(o_diff_flat),
    .o_first(o_first), .o_last(o_last), .o_length_mode(o_length_mode),
    .o_err_max(o_err_max)
  );

  // ---------------- clock ----------------
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [LANES*W-1:0] diff;
    logic               first;
    logic               last;
    logic [3:0]         mode;
    logic               err;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_e;
  bit   have_last = 0;

  int n_checks = 0;
  int n_fail   = 0;

  int         m_pos = 0;
  int         m_len = 1;
  logic [3:0] m_mode = 4'd0;
  logic [W-1:0] m_max = 16'h8000;
  logic       m_err = 1'b0;

  task automatic check(input string tag, input logic [LANES*W-1:0] act,
                       input logic [LANES*W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int tb_len(input logic [3:0] mode);
    if (mode >= 3 && mode <= 13) return int'(mode) - 1;
    return 1;
  endfunction

  function automatic logic [W-1:0] exp_lane(input logic [W-1:0] x, input logic [W-1:0] m);
    int d;
    logic [31:0] t;
    d = int'($signed(x)) - int'($signed(m));
    if (d > 0) return 16'h0000;
    if (d < -32768) return 16'h8000;
    t = d;
    return t[15:0];
  endfunction

  function automatic logic [LANES*W-1:0] rand_lanes();
    logic [LANES*W-1:0] v;
    for (int k = 0; k < LANES; k++) v[k*W +: W] = W'($urandom_range(0, 65535));
    return v;
  endfunction

  function automatic logic [LANES*W-1:0] fill_lanes(input logic [W-1:0] val);
    logic [LANES*W-1:0] v;
    for (int k = 0; k < LANES; k++) v[k*W +: W] = val;
    return v;
  endfunction

  task automatic model_push(input logic [3:0] mode, input logic [W-1:0] mx,
                            input logic [LANES*W-1:0] lanes);
    exp_t e;
    if (m_pos == 0) begin
      m_mode = mode;
      m_max  = mx;
      m_len  = tb_len(mode);
    end else if (mx != m_max) begin
      m_err = 1'b1;
    end
    e.first = (m_pos == 0);
    e.last  = (m_pos == m_len - 1);
    e.mode  = m_mode;
    e.err   = m_err;
    for (int k = 0; k < LANES; k++) e.diff[k*W +: W] = exp_lane(lanes[k*W +: W], mx);
    exp_q.push_back(e);
    m_pos = e.last ? 0 : m_pos + 1;
  endtask

  // ---------------- monitor ----------------
  bit adv_e = 0;
  bit rst_e = 1;

  always @(posedge i_clk) begin
    adv_e = i_en && !i_rst;
    rst_e = i_rst;
  end

  always @(negedge i_clk) begin
    exp_t e;
    if (adv_e) begin
      if (o_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1'b1, 1'b0);
          have_last = 0;
        end else begin
          e = exp_q.pop_front();
          check("diff",  o_diff_flat,   e.diff);
          check("first", o_first,       e.first);
          check("last",  o_last,        e.last);
          check("mode",  o_length_mode, e.mode);
          check("err",   o_err_max,     e.err);
          last_e    = e;
          have_last = 1;
        end
      end else begin
        have_last = 0;
      end
    end else if (!rst_e && have_last) begin
      check("stall_valid", o_valid,     1'b1);
      check("stall_diff",  o_diff_flat, last_e.diff);
      check("stall_first", o_first,     last_e.first);
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic en, input logic valid, input logic [3:0] mode,
                       input logic [W-1:0] mx, input logic [LANES*W-1:0] lanes);
    i_en          = en;
    i_valid       = valid;
    i_length_mode = mode;
    i_global_max  = mx;
    i_in_flat     = lanes;
    if (en && valid) model_push(mode, mx, lanes);
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 4'd0, 16'h0, rand_lanes());
  endtask

  task automatic do_reset();
    i_rst   = 1'b1;
    i_valid = 1'b0;
    @(posedge i_clk);
    #1;
    check("rst_valid", o_valid,       1'b0);
    check("rst_diff",  o_diff_flat,   '0);
    check("rst_first", o_first,       1'b0);
    check("rst_last",  o_last,        1'b0);
    check("rst_mode",  o_length_mode, 4'd0);
    check("rst_err",   o_err_max,     1'b0);
    exp_q.delete();
    have_last = 0;
    m_pos  = 0;
    m_len  = 1;
    m_mode = 4'd0;
    m_max  = 16'h8000;
    m_err  = 1'b0;
    i_rst  = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [LANES*W-1:0] l;
    logic [W-1:0] mx;
    i_rst = 1'b1; i_en = 1'b1; i_valid = 1'b0;
    i_global_max = '0; i_length_mode = '0; i_in_flat = '0;
    do_reset();

    // mode 3 two-beat group, lane0 = 100 then 40 against max 100
    l = rand_lanes(); l[15:0] = 16'd100;
    drive(1, 1, 4'd3, 16'd100, l);
    l = rand_lanes(); l[15:0] = 16'd40;
    drive(1, 1, 4'd3, 16'd100, l);
    idle(3);

    // saturation corners, single-beat groups
    drive(1, 1, 4'd0, 16'h7FFF, fill_lanes(16'h8000));
    drive(1, 1, 4'd0, 16'd3, fill_lanes(16'd5));
    drive(1, 1, 4'd15, 16'h8000, fill_lanes(16'h7FFF));
    idle(3);

    // mode 13 (12 beats, mode pin wiggled mid-group) then a mode 3 group
    for (int i = 0; i < 12; i++) drive(1, 1, (i == 0) ? 4'd13 : 4'd7, 16'd1234, rand_lanes());
    for (int i = 0; i < 2; i++) drive(1, 1, 4'd3, 16'hFFFB, rand_lanes());
    idle(3);

    // mode 5 with a max glitch on beat 2, then a clean group: error stays
    for (int i = 0; i < 4; i++) drive(1, 1, 4'd5, (i == 2) ? 16'd51 : 16'd50, rand_lanes());
    for (int i = 0; i < 2; i++) drive(1, 1, 4'd3, 16'd9, rand_lanes());
    idle(3);
    do_reset();

    // stall pattern 1,0,0,1 with valid beats every cycle
    for (int i = 0; i < 16; i++) begin
      if (i % 4 == 0 || i % 4 == 3) drive(1, 1, 4'd4, 16'd77, rand_lanes());
      else drive(0, 1, 4'd9, 16'd5, rand_lanes());
    end
    idle(3);

    // reset after beat 1 of a mode-6 group, then a fresh mode-3 group
    for (int i = 0; i < 2; i++) drive(1, 1, 4'd6, 16'd300, rand_lanes());
    do_reset();
    for (int i = 0; i < 2; i++) drive(1, 1, 4'd3, 16'd2000, rand_lanes());
    idle(3);

    // random traffic
    mx = 16'd1000;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 15) == 0) mx = W'($urandom_range(0, 65535));
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            4'($urandom_range(0, 15)), mx, rand_lanes());
    end
    idle(4);

    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
